// File: rtl/decode_stage.sv
// Registered instruction-decode stage for the accumulator CPU.
// Decodes one instruction per cycle into datapath controls behind a
// valid/ready pipeline register. A per-accumulator flag-age counter holds
// conditional branches until their flags have settled. A squash counter
// drops wrong-path instructions after a taken branch or jump.
module decode_stage #(
    parameter int NACC     = 2,
    parameter int OPND_W   = 9,
    parameter int FLAG_LAT = 2,
    parameter int SQUASH   = 1,
    // Derived; leave at their defaults.
    parameter int ACC_W    = $clog2(NACC),
    parameter int INSN_W   = 6 + ACC_W + OPND_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INSN_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3*NACC-1:0] flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*NACC-1:0] selAcc,
    output logic [2:0]        aluFunc,
    output logic              srcImm,
    output logic [ACC_W-1:0]  accIdx,
    output logic              wrEnable,
    output logic              jmpEnable,
    output logic              branchEnable,
    output logic              illegal,
    output logic [OPND_W-1:0] operand
);

    // Instruction fields
    logic [5:0]        opc;
    logic [1:0]        opc_grp;
    logic              opc_src;
    logic [2:0]        opc_func;
    logic [ACC_W-1:0]  acc_f;
    logic [OPND_W-1:0] opd_f;

    assign opc      = in[INSN_W-1 -: 6];
    assign opc_grp  = opc[5:4];
    assign opc_src  = opc[3];
    assign opc_func = opc[2:0];
    assign acc_f    = in[OPND_W +: ACC_W];
    assign opd_f    = in[OPND_W-1:0];

    // State
    logic [2:0]        fcnt_reg [NACC];
    logic [1:0]        scnt_reg;
    logic              out_valid_reg;
    logic [2*NACC-1:0] sel_acc_reg;
    logic [2:0]        alu_func_reg;
    logic              src_imm_reg;
    logic [ACC_W-1:0]  acc_idx_reg;
    logic              wr_en_reg;
    logic              jmp_en_reg;
    logic              br_en_reg;
    logic              illegal_reg;
    logic [OPND_W-1:0] operand_reg;

    // Decode results
    logic [1:0]        dec_code;
    logic [2:0]        dec_alu;
    logic              dec_src;
    logic              dec_wr;
    logic              dec_jmp;
    logic              dec_is_br;
    logic              dec_cond;
    logic              dec_ill;
    logic [2*NACC-1:0] dec_sel_vec;
    logic [2:0]        cur_flags;
    logic [2:0]        cur_fcnt;

    // Handshake
    logic advance;
    logic stall;
    logic accept;
    logic squash;
    logic live;
    logic writes_flags;

    // Select the flags and flag-age counter of the addressed accumulator
    always_comb begin
        cur_flags = 3'b000;
        cur_fcnt  = 3'b000;
        for (int k = 0; k < NACC; k++) begin
            if (acc_f == ACC_W'(k)) begin
                cur_flags = flags[3*k +: 3];
                cur_fcnt  = fcnt_reg[k];
            end
        end
    end

    // Opcode decode; unknown codes become NOP with illegal set
    always_comb begin
        dec_code  = 2'b00;
        dec_alu   = 3'b000;
        dec_src   = 1'b0;
        dec_wr    = 1'b0;
        dec_jmp   = 1'b0;
        dec_is_br = 1'b0;
        dec_cond  = 1'b0;
        dec_ill   = 1'b0;
        case (opc_grp)
            2'b00: dec_ill = (opc[3:0] != 4'b0000);
            2'b01: begin
                if (opc_func == 3'b000)      dec_code = opc_src ? 2'b01 : 2'b11;
                else if (opc_func == 3'b001) dec_wr   = 1'b1;
                else                         dec_ill  = 1'b1;
            end
            2'b10: begin
                if (opc_func <= 3'b101) begin
                    dec_code = 2'b10;
                    dec_alu  = opc_func;
                    dec_src  = opc_src;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: begin
                case (opc[3:0])
                    4'b0000: dec_jmp = 1'b1;
                    4'b0001: begin dec_is_br = 1'b1; dec_cond =  cur_flags[2]; end
                    4'b0010: begin dec_is_br = 1'b1; dec_cond = !cur_flags[2]; end
                    4'b0011: begin dec_is_br = 1'b1; dec_cond =  cur_flags[1]; end
                    4'b0100: begin dec_is_br = 1'b1; dec_cond = !cur_flags[1]; end
                    4'b0101: begin dec_is_br = 1'b1; dec_cond =  cur_flags[0]; end
                    4'b0110: begin dec_is_br = 1'b1; dec_cond = !cur_flags[0]; end
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    // Route the load code onto the addressed accumulator's selAcc pair
    for (genvar gi = 0; gi < NACC; gi++) begin : g_sel
        assign dec_sel_vec[2*gi +: 2] = (acc_f == ACC_W'(gi)) ? dec_code : 2'b00;
    end

    assign writes_flags = (dec_code != 2'b00);
    assign squash       = (scnt_reg != 2'd0);
    assign advance      = !out_valid_reg || out_ready;
    // Squashed branches never execute, so they never need to wait for flags
    assign stall        = in_valid && dec_is_br && !squash && (cur_fcnt != 3'd0);
    assign in_ready     = advance && !stall && !reset;
    assign accept       = in_valid && in_ready;
    assign live         = accept && !squash;

    // Per-accumulator flag-age counters; a fresh load overrides the countdown
    for (genvar gi = 0; gi < NACC; gi++) begin : g_fcnt
        always_ff @(posedge clk) begin
            if (reset) begin
                fcnt_reg[gi] <= 3'd0;
            end else if (live && writes_flags && (acc_f == ACC_W'(gi))) begin
                fcnt_reg[gi] <= 3'(FLAG_LAT);
            end else if (fcnt_reg[gi] != 3'd0) begin
                fcnt_reg[gi] <= fcnt_reg[gi] - 3'd1;
            end
        end
    end

    // Squash counter: armed by a live JMP or taken branch, spent per accepted insn
    always_ff @(posedge clk) begin
        if (reset) begin
            scnt_reg <= 2'd0;
        end else if (accept) begin
            if (squash)
                scnt_reg <= scnt_reg - 2'd1;
            else if (dec_jmp || (dec_is_br && dec_cond))
                scnt_reg <= 2'(SQUASH);
        end
    end

    // Output pipeline register; everything reads zero while not valid
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            sel_acc_reg   <= '0;
            alu_func_reg  <= 3'b000;
            src_imm_reg   <= 1'b0;
            acc_idx_reg   <= '0;
            wr_en_reg     <= 1'b0;
            jmp_en_reg    <= 1'b0;
            br_en_reg     <= 1'b0;
            illegal_reg   <= 1'b0;
            operand_reg   <= '0;
        end else if (advance) begin
            out_valid_reg <= live;
            if (live) begin
                sel_acc_reg  <= dec_sel_vec;
                alu_func_reg <= dec_alu;
                src_imm_reg  <= dec_src;
                acc_idx_reg  <= acc_f;
                wr_en_reg    <= dec_wr;
                jmp_en_reg   <= dec_jmp;
                br_en_reg    <= dec_is_br && dec_cond;
                illegal_reg  <= dec_ill;
                operand_reg  <= opd_f;
            end else begin
                sel_acc_reg  <= '0;
                alu_func_reg <= 3'b000;
                src_imm_reg  <= 1'b0;
                acc_idx_reg  <= '0;
                wr_en_reg    <= 1'b0;
                jmp_en_reg   <= 1'b0;
                br_en_reg    <= 1'b0;
                illegal_reg  <= 1'b0;
                operand_reg  <= '0;
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign selAcc       = sel_acc_reg;
    assign aluFunc      = alu_func_reg;
    assign srcImm       = src_imm_reg;
    assign accIdx       = acc_idx_reg;
    assign wrEnable     = wr_en_reg;
    assign jmpEnable    = jmp_en_reg;
    assign branchEnable = br_en_reg;
    assign illegal      = illegal_reg;
    assign operand      = operand_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (NACC=2, OPND_W=9, FLAG_LAT=2, SQUASH=1).
// A cycle-level reference model checks every cycle; a vector table and a few
// hand sequences check against fixed expected values.
module tb_decode_stage;

    localparam int NACC     = 2;
    localparam int FLAG_LAT = 2;
    localparam int SQUASH   = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_sig = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  flags = 6'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  selAcc;
    logic [2:0]  aluFunc;
    logic        srcImm;
    logic [0:0]  accIdx;
    logic        wrEnable, jmpEnable, branchEnable, illegal;
    logic [8:0]  operand;

    decode_stage #(.NACC(2), .OPND_W(9), .FLAG_LAT(2), .SQUASH(1)) dut (
        .clk(clk), .reset(reset), .in(in_sig), .in_valid(in_valid), .in_ready(in_ready),
        .flags(flags), .out_valid(out_valid), .out_ready(out_ready), .selAcc(selAcc),
        .aluFunc(aluFunc), .srcImm(srcImm), .accIdx(accIdx), .wrEnable(wrEnable),
        .jmpEnable(jmpEnable), .branchEnable(branchEnable), .illegal(illegal),
        .operand(operand)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [3:0] sel;
        logic [2:0] alu;
        logic       src;
        logic       acc;
        logic       wr, jmp, br, ill;
        logic [8:0] opd;
    } obs_t;

    typedef struct {
        string       name;
        logic [15:0] insn;
        logic [5:0]  fl;
        obs_t        exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic obs_t observed();
        obs_t o;
        o = {out_valid, selAcc, aluFunc, srcImm, accIdx[0], wrEnable, jmpEnable,
             branchEnable, illegal, operand};
        return o;
    endfunction

    function automatic logic [15:0] mk(input logic [5:0] opc, input logic a, input logic [8:0] opd);
        return {opc, a, opd};
    endfunction

    function automatic obs_t ex(input logic [3:0] sel, input logic [2:0] alu, input logic src,
                                input logic a, input logic [3:0] ctl, input logic [8:0] opd);
        obs_t o;
        o.v = 1'b1; o.sel = sel; o.alu = alu; o.src = src; o.acc = a;
        {o.wr, o.jmp, o.br, o.ill} = ctl;
        o.opd = opd;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Decode from the opcode rules: groups, function codes, branch condition table.
    function automatic obs_t model_decode(input logic [15:0] insn, input logic [5:0] fl);
        obs_t o;
        int   opc, grp, low4, func, a, k;
        logic bitv;
        o = '0;
        opc = int'(insn[15:10]); grp = opc / 16; low4 = opc % 16; func = opc % 8;
        a = int'(insn[9]);
        o.v = 1'b1; o.acc = insn[9]; o.opd = insn[8:0];
        if (opc == 0) begin
        end else if (grp == 1 && func == 0) begin
            o.sel[2*a +: 2] = (low4 >= 8) ? 2'b01 : 2'b11;
        end else if (grp == 1 && func == 1) begin
            o.wr = 1'b1;
        end else if (grp == 2 && func <= 5) begin
            o.sel[2*a +: 2] = 2'b10; o.alu = insn[12:10]; o.src = insn[13];
        end else if (grp == 3 && low4 == 0) begin
            o.jmp = 1'b1;
        end else if (grp == 3 && low4 <= 6) begin
            // pairs (1,2)->z, (3,4)->c, (5,6)->n; odd code tests for 1
            k = (low4 - 1) / 2;
            bitv = fl[3*a + 2 - k];
            o.br = (low4 % 2 == 1) ? bitv : !bitv;
        end else begin
            o.ill = 1'b1;
        end
        return o;
    endfunction

    function automatic logic is_branch(input logic [15:0] insn);
        int opc;
        opc = int'(insn[15:10]);
        return (opc / 16 == 3) && (opc % 16 >= 1) && (opc % 16 <= 6);
    endfunction

    obs_t m_out = '0;
    int   m_fcnt [NACC];
    int   m_scnt = 0;

    // Per-cycle monitor: compare, then advance the model over the coming edge
    always @(negedge clk) begin : monitor
        obs_t d;
        logic adv, stall_m, rdy, acc_ok, drop;
        int   a;
        a = int'(in_sig[9]);
        adv = !m_out.v || out_ready;
        stall_m = in_valid && is_branch(in_sig) && (m_scnt == 0) && (m_fcnt[a] != 0);
        rdy = adv && !stall_m && !reset;
        check_bit("mon_in_ready", in_ready, rdy);
        check_obs("mon_outputs", observed(), m_out);
        if (reset) begin
            m_out = '0;
            for (int k = 0; k < NACC; k++) m_fcnt[k] = 0;
            m_scnt = 0;
        end else begin
            acc_ok = in_valid && rdy;
            drop = acc_ok && (m_scnt > 0);
            d = model_decode(in_sig, flags);
            for (int k = 0; k < NACC; k++) begin
                if (acc_ok && !drop && d.sel != 4'b0 && a == k) m_fcnt[k] = FLAG_LAT;
                else if (m_fcnt[k] > 0) m_fcnt[k] = m_fcnt[k] - 1;
            end
            if (drop) m_scnt = m_scnt - 1;
            else if (acc_ok && (d.jmp || d.br)) m_scnt = SQUASH;
            if (adv) m_out = (acc_ok && !drop) ? d : '0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] insn, input logic [5:0] fl);
        int n;
        @(posedge clk); #1;
        in_sig = insn; flags = fl; in_valid = 1'b1; n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 20 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sig = 16'h0; flags = 6'h0;
    endtask

    function automatic logic [15:0] rand_insn();
        logic [5:0] opc;
        case ($urandom_range(0, 15))
            0:  opc = 6'b000000;
            1:  opc = 6'b010000;
            2:  opc = 6'b011000;
            3:  opc = 6'b010001;
            4:  opc = 6'b100000;
            5:  opc = 6'b101001;
            6:  opc = 6'b100100;
            7:  opc = 6'b110000;
            8:  opc = 6'b110001;
            9:  opc = 6'b110010;
            10: opc = 6'b110011;
            11: opc = 6'b110100;
            12: opc = 6'b110101;
            13: opc = 6'b110110;
            default: opc = 6'($urandom);
        endcase
        return {opc, 1'($urandom), 9'($urandom)};
    endfunction

    vec_t tbl[$];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    initial begin
        // Reset held with a valid instruction waiting
        in_sig = mk(6'b011000, 1'b1, 9'h005); in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_bit("rst_in_ready", in_ready, 1'b0);
            check_obs("rst_outputs", observed(), '0);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_bit("post_rst_in_ready", in_ready, 1'b1);
        // LDC acc1 #5 then ADD acc0 mem 0x010 back to back
        @(posedge clk); #1 in_sig = mk(6'b100000, 1'b0, 9'h010);
        @(negedge clk);
        check_obs("ldc_out", observed(), ex(4'b0100, 3'd0, 1'b0, 1'b1, 4'b0000, 9'h005));
        @(posedge clk); #1 in_valid = 1'b0; in_sig = 16'h0;
        @(negedge clk);
        check_obs("add_out", observed(), ex(4'b0010, 3'd0, 1'b0, 1'b0, 4'b0000, 9'h010));

        // Flag interlock: ADD acc0 then BEQ acc0 stalls FLAG_LAT cycles
        repeat (4) @(posedge clk);
        #1 in_sig = mk(6'b100000, 1'b0, 9'h011); in_valid = 1'b1; flags = 6'h0;
        @(negedge clk); check_bit("stall_add_ready", in_ready, 1'b1);
        @(posedge clk); #1 in_sig = mk(6'b110001, 1'b0, 9'h0C3); flags = 6'b000100;
        @(negedge clk); check_bit("stall_1", in_ready, 1'b0);
        check_obs("stall_add_out", observed(), ex(4'b0010, 3'd0, 1'b0, 1'b0, 4'b0000, 9'h011));
        @(negedge clk); check_bit("stall_2", in_ready, 1'b0);
        @(negedge clk); check_bit("stall_release", in_ready, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0; in_sig = 16'h0; flags = 6'h0;
        @(negedge clk);
        check_obs("beq_taken", observed(), ex(4'b0000, 3'd0, 1'b0, 1'b0, 4'b0010, 9'h0C3));
        send(mk(6'b000000, 1'b0, 9'h001), 6'h0);
        @(negedge clk); check_obs("beq_squash", observed(), '0);

        // Backpressure: out_ready low for 3 cycles while output valid
        @(posedge clk); #1 in_sig = mk(6'b011000, 1'b0, 9'h007); in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b0; in_sig = mk(6'b100000, 1'b1, 9'h021);
        repeat (3) begin
            @(negedge clk);
            check_obs("hold_out", observed(), ex(4'b0001, 3'd0, 1'b0, 1'b0, 4'b0000, 9'h007));
            check_bit("hold_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk); check_bit("resume_ready_0", in_ready, 1'b1);
        @(posedge clk); #1 in_sig = mk(6'b101001, 1'b0, 9'h022);
        @(negedge clk); check_bit("resume_ready_1", in_ready, 1'b1);
        check_obs("resume_add", observed(), ex(4'b1000, 3'd0, 1'b0, 1'b1, 4'b0000, 9'h021));
        @(posedge clk); #1 in_sig = mk(6'b100011, 1'b1, 9'h023);
        @(negedge clk); check_bit("resume_ready_2", in_ready, 1'b1);
        check_obs("resume_sub", observed(), ex(4'b0010, 3'd1, 1'b1, 1'b0, 4'b0000, 9'h022));
        @(posedge clk); #1 in_valid = 1'b0; in_sig = 16'h0;
        @(negedge clk);
        check_obs("resume_or", observed(), ex(4'b1000, 3'd3, 1'b0, 1'b1, 4'b0000, 9'h023));

        // Vector table: one instruction at a time, fixed expectations
        tbl.push_back('{"ldc",        mk(6'b011000,1'b1,9'h005), 6'h00, ex(4'b0100,3'd0,1'b0,1'b1,4'b0000,9'h005)});
        tbl.push_back('{"add_mem",    mk(6'b100000,1'b0,9'h010), 6'h00, ex(4'b0010,3'd0,1'b0,1'b0,4'b0000,9'h010)});
        tbl.push_back('{"ld",         mk(6'b010000,1'b0,9'h020), 6'h00, ex(4'b0011,3'd0,1'b0,1'b0,4'b0000,9'h020)});
        tbl.push_back('{"st",         mk(6'b010001,1'b1,9'h030), 6'h00, ex(4'b0000,3'd0,1'b0,1'b1,4'b1000,9'h030)});
        tbl.push_back('{"sub_imm",    mk(6'b101001,1'b1,9'h0AA), 6'h00, ex(4'b1000,3'd1,1'b1,1'b1,4'b0000,9'h0AA)});
        tbl.push_back('{"asr_mem",    mk(6'b100101,1'b0,9'h013), 6'h00, ex(4'b0010,3'd5,1'b0,1'b0,4'b0000,9'h013)});
        tbl.push_back('{"ill_3f",     mk(6'b111111,1'b1,9'h1FF), 6'h00, ex(4'b0000,3'd0,1'b0,1'b1,4'b0001,9'h1FF)});
        tbl.push_back('{"bcc_c1_nt",  mk(6'b110100,1'b1,9'h044), 6'h10, ex(4'b0000,3'd0,1'b0,1'b1,4'b0000,9'h044)});
        tbl.push_back('{"nop_no_sq",  mk(6'b000000,1'b0,9'h000), 6'h00, ex(4'b0000,3'd0,1'b0,1'b0,4'b0000,9'h000)});
        tbl.push_back('{"beq_z0",     mk(6'b110001,1'b0,9'h0C3), 6'h04, ex(4'b0000,3'd0,1'b0,1'b0,4'b0010,9'h0C3)});
        tbl.push_back('{"sq_nop",     mk(6'b000000,1'b0,9'h000), 6'h00, '0});
        tbl.push_back('{"jmp",        mk(6'b110000,1'b0,9'h155), 6'h00, ex(4'b0000,3'd0,1'b0,1'b0,4'b0100,9'h155)});
        tbl.push_back('{"sq_st",      mk(6'b010001,1'b0,9'h066), 6'h00, '0});
        tbl.push_back('{"nop",        mk(6'b000000,1'b1,9'h07F), 6'h00, ex(4'b0000,3'd0,1'b0,1'b1,4'b0000,9'h07F)});
        tbl.push_back('{"bne_z1_nt",  mk(6'b110010,1'b1,9'h100), 6'h20, ex(4'b0000,3'd0,1'b0,1'b1,4'b0000,9'h100)});
        tbl.push_back('{"ill_grp0",   mk(6'b001000,1'b0,9'h001), 6'h00, ex(4'b0000,3'd0,1'b0,1'b0,4'b0001,9'h001)});
        tbl.push_back('{"ill_alu6",   mk(6'b100110,1'b1,9'h002), 6'h00, ex(4'b0000,3'd0,1'b0,1'b1,4'b0001,9'h002)});
        tbl.push_back('{"bpl_n0",     mk(6'b110110,1'b0,9'h0AB), 6'h06, ex(4'b0000,3'd0,1'b0,1'b0,4'b0010,9'h0AB)});
        tbl.push_back('{"sq_ldc",     mk(6'b011000,1'b1,9'h001), 6'h00, '0});
        tbl.push_back('{"and_imm",    mk(6'b101010,1'b1,9'h0F0), 6'h00, ex(4'b1000,3'd2,1'b1,1'b1,4'b0000,9'h0F0)});
        tbl.push_back('{"bmi_n1",     mk(6'b110101,1'b1,9'h011), 6'h08, ex(4'b0000,3'd0,1'b0,1'b1,4'b0010,9'h011)});
        tbl.push_back('{"sq_asl",     mk(6'b100100,1'b0,9'h000), 6'h00, '0});
        tbl.push_back('{"st_src1",    mk(6'b011001,1'b0,9'h009), 6'h00, ex(4'b0000,3'd0,1'b0,1'b0,4'b1000,9'h009)});
        tbl.push_back('{"bcs_c0_nt",  mk(6'b110011,1'b0,9'h012), 6'h00, ex(4'b0000,3'd0,1'b0,1'b0,4'b0000,9'h012)});
        foreach (tbl[i]) begin
            send(tbl[i].insn, tbl[i].fl);
            @(negedge clk);
            check_obs(tbl[i].name, observed(), tbl[i].exp);
        end

        // Reset in the middle of a squash window
        send(mk(6'b110000, 1'b0, 9'h155), 6'h0);
        @(negedge clk);
        check_obs("jmp_out", observed(), ex(4'b0000, 3'd0, 1'b0, 1'b0, 4'b0100, 9'h155));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        send(mk(6'b000000, 1'b1, 9'h05A), 6'h0);
        @(negedge clk);
        check_obs("rst_clears_squash", observed(), ex(4'b0000, 3'd0, 1'b0, 1'b1, 4'b0000, 9'h05A));

        // Reset right after a flag-writer abandons the pending interlock
        @(posedge clk); #1 in_sig = mk(6'b100000, 1'b1, 9'h003); in_valid = 1'b1;
        @(negedge clk); check_bit("pre_stall_ready", in_ready, 1'b1);
        @(posedge clk); #1 in_sig = mk(6'b110001, 1'b1, 9'h0EE); reset = 1'b1;
        @(negedge clk); check_bit("rst_stall_ready", in_ready, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); check_bit("stall_abandoned", in_ready, 1'b1);
        check_obs("rst_cleared_out", observed(), '0);
        @(posedge clk); #1 in_valid = 1'b0; in_sig = 16'h0;
        @(negedge clk);
        check_obs("beq_z1_nt", observed(), ex(4'b0000, 3'd0, 1'b0, 1'b1, 4'b0000, 9'h0EE));
        send(mk(6'b000000, 1'b0, 9'h000), 6'h0);

        // Randomised traffic, checked by the monitor's model
        repeat (3000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sig    = rand_insn();
            flags     = 6'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the accumulator CPU, sitting between the fetch register and the execute/datapath muxes. Generalises the combinational decoder to NACC accumulators and configurable field widths. Adds three things the combinational decoder lacks: a valid/ready pipeline register, a per-accumulator flag-staleness interlock that holds conditional branches, and a squash counter that drops wrong-path instructions after a taken branch or jump.

## Interface
- NACC, 2: number of accumulators, 2..4; ACC_W = clog2(NACC).
- OPND_W, 9: operand / address / immediate field width.
- FLAG_LAT, 2: cycles from issuing a flag-writing instruction until its flags are valid on `flags`, 1..7.
- SQUASH, 1: wrong-path instructions dropped after a taken branch or jump, 0..3.
- INSN_W, derived: 6 + ACC_W + OPND_W (16 by default).
- Instruction layout: {opc[5:0], acc[ACC_W-1:0], operand[OPND_W-1:0]}.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- in  in  INSN_W  instruction from fetch.
- in_valid  in  1  `in` holds a valid instruction.
- in_ready  out  1  stage accepts `in` this cycle (combinational).
- flags  in  3*NACC  per-accumulator {z,c,n}; acc k occupies [3k+2:3k].
- out_valid  out  1  decoded outputs are valid.
- out_ready  in  1  execute consumes the outputs this cycle.
- selAcc  out  2*NACC  per-accumulator load code: 00 hold, 01 immediate, 10 ALU, 11 memory.
- aluFunc  out  3  opc[2:0] for ALU-group instructions, 0 otherwise.
- srcImm  out  1  ALU operand source: 1 immediate, 0 memory.
- accIdx  out  ACC_W  accumulator field.
- wrEnable, jmpEnable, branchEnable, illegal  out  1 each.
- operand  out  OPND_W  operand field; also the jump/branch target.

## Operation
- Opcode map, opc = {grp[1:0], src, func[2:0]}:
  - 000000: NOP.
  - Group 01: func 000 = LD (src 0, memory) or LDC (src 1, immediate); func 001 = ST (wrEnable=1, src ignored).
  - Group 10, ALU: func 000 ADD, 001 SUB, 010 AND, 011 OR, 100 ASL, 101 ASR. selAcc[acc]=10; srcImm=src.
  - Group 11, flow: opc[3:0] 0000 = JMP (jmpEnable=1). Branches on flags of `acc`: 0001 EQ (z=1), 0010 NE (z=0), 0011 CS (c=1), 0100 CC (c=0), 0101 MI (n=1), 0110 PL (n=0).
  - Any other code decodes as NOP with illegal=1.
- A branch emits branchEnable=1 only if its condition is true at acceptance; otherwise it emits branchEnable=0.
- Flag counter fcnt[k], 3 bits per accumulator:
  - Loaded with FLAG_LAT when LD, LDC or an ALU instruction targeting acc k is accepted and not squashed.
  - Otherwise decrements toward 0 each cycle.
  - If a load and a decrement coincide, the load wins.
- Stall: a non-squashed branch at the input whose fcnt[acc] is nonzero holds in_ready low.
- Squash counter scnt:
  - Loaded with SQUASH on acceptance of JMP or a taken branch.
  - While scnt>0, each accepted instruction is dropped: out_valid does not rise, no fcnt load, no stall, and scnt decrements.
- Unused selAcc pairs are 00. All control outputs are 0 whenever out_valid=0.

## Timing
- advance = !out_valid || out_ready.
- in_ready = advance && !stall && !reset.
- Acceptance = in_valid && in_ready. Decoded outputs appear the cycle after acceptance: latency 1.
- When out_valid=1 and out_ready=0, all outputs hold stable.
- Back-to-back throughput is 1 per cycle when out_ready=1 and there is no stall.
- Reset: out_valid, all control outputs, operand, accIdx, fcnt and scnt are cleared to 0 on the next edge. Reset mid-stall or mid-squash abandons the pending state.
- The branch condition samples `flags` in the acceptance cycle. With fcnt=0, `flags` are final.

## Test plan
- Reset with in_valid=1 held -> in_ready=0, all outputs 0; out_valid=1 one cycle after reset is released.
- LDC acc1 imm 0x05, then ADD acc0 mem 0x010 back to back, out_ready=1 -> selAcc=01 on acc1 at T+1, selAcc=10 on acc0 with srcImm=0 at T+2, illegal=0.
- With FLAG_LAT=2: ADD acc0, then BAEQ acc0 -> in_ready low for 2 cycles. The branch is then accepted with z0=1 and emits branchEnable=1, operand=target.
- Taken JMP 0x155, SQUASH=1, followed by ST and NOP -> ST is dropped with wrEnable never asserted; NOP is emitted next.
- out_ready=0 for 3 cycles while out_valid=1 -> outputs hold and in_ready=0; one instruction is accepted per cycle after out_ready returns to 1.
- opc=6'b111111 -> emitted with illegal=1 and all enables 0. BBCC with c1=1 -> branchEnable=0 and no squash.
